// File: rtl/kernel_run_sequencer.sv
// Multi-run driver for an HLS kernel: reset/start/wait per run, latency measurement, watchdog abort.
// Optional run statistics (stat_min/stat_max/stat_sum) are built when KRS_STATS_EN is defined.
module kernel_run_sequencer #(
    parameter int unsigned CYC_W       = 32,
    parameter int unsigned RUNS_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 200000000,
    parameter int unsigned RES_DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       go,
    input  logic [RUNS_W-1:0]          num_runs,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       kernel_rst_n,
    output logic                       kernel_start,
    input  logic                       kernel_done,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2+RUNS_W+CYC_W-1:0]  res_data
`ifdef KRS_STATS_EN
    ,
    output logic [CYC_W-1:0]           stat_min,
    output logic [CYC_W-1:0]           stat_max,
    output logic [CYC_W+RUNS_W-1:0]    stat_sum
`endif
);

    localparam int unsigned REC_W = 2 + RUNS_W + CYC_W;
    localparam int unsigned PTR_W = $clog2(RES_DEPTH);
    localparam logic [CYC_W-1:0] TimeoutVal = CYC_W'(TIMEOUT_CYC);
    localparam logic [1:0] StatOk      = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StRst0, StRst1, StStart, StWait, StReport, StFin
    } state_e;

    state_e              state_q;
    logic [RUNS_W-1:0]   runs_q;
    logic [RUNS_W-1:0]   run_idx_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [CYC_W-1:0]    cycles_q;
    logic [1:0]          status_q;
    logic                pushed_q;

    logic [REC_W-1:0]    fifo_mem [RES_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic                full;
    logic                push;
    logic                pop;

    assign full      = (count_q == (PTR_W+1)'(RES_DEPTH));
    assign res_valid = (count_q != '0);
    assign res_data  = fifo_mem[rd_ptr_q];
    assign pop       = res_valid && res_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign push      = (state_q == StReport) && !pushed_q && (!full || pop);

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {status_q, run_idx_q, cycles_q};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            kernel_rst_n <= 1'b0;
            kernel_start <= 1'b0;
            pushed_q     <= 1'b0;
            runs_q       <= '0;
            run_idx_q    <= '0;
            cyc_q        <= '0;
            cycles_q     <= '0;
            status_q     <= StatOk;
        end else begin
            seq_done     <= 1'b0;
            kernel_start <= 1'b0;
            kernel_rst_n <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        if (num_runs == '0) begin
                            seq_done <= 1'b1;
                        end else begin
                            runs_q       <= num_runs;
                            run_idx_q    <= '0;
                            busy         <= 1'b1;
                            kernel_rst_n <= 1'b0;
                            state_q      <= StRst0;
                        end
                    end
                end
                StRst0: begin
                    kernel_rst_n <= 1'b0;
                    state_q      <= StRst1;
                end
                StRst1: begin
                    kernel_start <= 1'b1;
                    cyc_q        <= CYC_W'(1);
                    state_q      <= StStart;
                end
                StStart, StWait: begin
                    // Done is checked before the watchdog so a done on the limit cycle is OK.
                    if (kernel_done) begin
                        status_q <= StatOk;
                        cycles_q <= cyc_q;
                        state_q  <= StReport;
                    end else if (cyc_q >= TimeoutVal) begin
                        status_q <= StatTimeout;
                        cycles_q <= TimeoutVal;
                        state_q  <= StReport;
                    end else begin
                        cyc_q   <= cyc_q + 1'b1;
                        state_q <= StWait;
                    end
                end
                StReport: begin
                    if (!pushed_q) begin
                        if (push) begin
                            if (status_q == StatTimeout || run_idx_q == runs_q - 1'b1) begin
                                seq_done <= 1'b1;
                                state_q  <= StFin;
                            end else begin
                                pushed_q <= 1'b1;
                            end
                        end
                    end else if (!full) begin
                        // Next run starts only once its result is guaranteed a slot.
                        pushed_q     <= 1'b0;
                        run_idx_q    <= run_idx_q + 1'b1;
                        kernel_rst_n <= 1'b0;
                        state_q      <= StRst0;
                    end
                end
                StFin: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef KRS_STATS_EN
    always_ff @(posedge clock) begin
        if (reset || (state_q == StIdle && go)) begin
            stat_min <= '1;
            stat_max <= '0;
            stat_sum <= '0;
        end else if (push && status_q == StatOk) begin
            if (cycles_q < stat_min) stat_min <= cycles_q;
            if (cycles_q > stat_max) stat_max <= cycles_q;
            stat_sum <= stat_sum + (CYC_W+RUNS_W)'(cycles_q);
        end
    end
`endif

endmodule

// File: tb/tb_kernel_run_sequencer.sv
// Bench for kernel_run_sequencer: kernel model with per-run done delays, random consumer,
// records and stats predicted from per-run delays.
module tb_kernel_run_sequencer;

    localparam int unsigned CYC_W   = 32;
    localparam int unsigned RUNS_W  = 8;
    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned REC_W   = 2 + RUNS_W + CYC_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              go = 1'b0;
    logic [RUNS_W-1:0] num_runs = '0;
    logic              busy;
    logic              seq_done;
    logic              kernel_rst_n;
    logic              kernel_start;
    logic              kernel_done = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [REC_W-1:0]  res_data;
`ifdef KRS_STATS_EN
    logic [CYC_W-1:0]        stat_min;
    logic [CYC_W-1:0]        stat_max;
    logic [CYC_W+RUNS_W-1:0] stat_sum;
    logic [CYC_W-1:0]        e_min;
    logic [CYC_W-1:0]        e_max;
    logic [CYC_W+RUNS_W-1:0] e_sum;
`endif

    int checks = 0;
    int failures = 0;

    logic [REC_W-1:0] exp_q[$];
    int               dly_q[$];
    int               kstarts = 0;
    bit               armed = 1'b0;
    int               kcnt = 0;
    int               kd = 0;
    bit               cons_en = 1'b0;
    bit               held = 1'b0;
    logic [REC_W-1:0] held_data = '0;

    kernel_run_sequencer #(
        .CYC_W      (CYC_W),
        .RUNS_W     (RUNS_W),
        .TIMEOUT_CYC(TIMEOUT),
        .RES_DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .go          (go),
        .num_runs    (num_runs),
        .busy        (busy),
        .seq_done    (seq_done),
        .kernel_rst_n(kernel_rst_n),
        .kernel_start(kernel_start),
        .kernel_done (kernel_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
`ifdef KRS_STATS_EN
        ,
        .stat_min    (stat_min),
        .stat_max    (stat_max),
        .stat_sum    (stat_sum)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Kernel model: raises done for one cycle, d cycles after the start cycle (d=0: same cycle).
    always @(negedge clock) begin
        kernel_done = 1'b0;
        if (reset) begin
            armed = 1'b0;
        end else if (kernel_start) begin
            kstarts++;
            armed = 1'b0;
            if (dly_q.size() != 0) begin
                kd = dly_q.pop_front();
                if (kd == 0) kernel_done = 1'b1;
                else begin
                    armed = 1'b1;
                    kcnt  = kd;
                end
            end
        end else if (armed) begin
            kcnt--;
            if (kcnt == 0) begin
                kernel_done = 1'b1;
                armed = 1'b0;
            end
        end
    end

    // Consumer: random ready; a pop happens at the next posedge when valid && ready here.
    always @(negedge clock) begin
        if (reset || !cons_en) res_ready = 1'b0;
        else res_ready = ($urandom_range(3) != 0);
        if (held && res_valid) check("res_data_stable", res_data, held_data);
        held      = res_valid && !res_ready && !reset;
        held_data = res_data;
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) check("spurious_record", res_valid, 0);
            else check("record", res_data, exp_q.pop_front());
        end
    end

    // Expected records from the delays: latency = delay + 1, watchdog aborts past TIMEOUT.
    task automatic plan(input int n, input int dl[$], output int nrec);
        int c;
        nrec = 0;
`ifdef KRS_STATS_EN
        e_min = '1;
        e_max = '0;
        e_sum = '0;
`endif
        for (int i = 0; i < n; i++) begin
            c = dl[i] + 1;
            dly_q.push_back(dl[i]);
            nrec++;
            if (c > int'(TIMEOUT)) begin
                exp_q.push_back({2'b10, RUNS_W'(i), CYC_W'(TIMEOUT)});
                break;
            end
            exp_q.push_back({2'b01, RUNS_W'(i), CYC_W'(c)});
`ifdef KRS_STATS_EN
            if (CYC_W'(c) < e_min) e_min = CYC_W'(c);
            if (CYC_W'(c) > e_max) e_max = CYC_W'(c);
            e_sum = e_sum + (CYC_W+RUNS_W)'(c);
`endif
        end
    endtask

    task automatic pulse_go(input int n);
        go = 1'b1;
        num_runs = RUNS_W'(n);
        @(posedge clock); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int nrec, input int s0);
        bit seen = 1'b0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            if (seq_done) seen = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        check("seq_done_seen", seen, 1);
        check("fin_busy", busy, 1);
        @(posedge clock); #1;
        check("seq_done_one_pulse", seq_done, 0);
        check("idle_busy", busy, 0);
        check("kernel_starts", kstarts - s0, nrec);
`ifdef KRS_STATS_EN
        check("stat_min", stat_min, e_min);
        check("stat_max", stat_max, e_max);
        check("stat_sum", stat_sum, e_sum);
`endif
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) begin
            @(posedge clock); #1;
        end
        check("records_drained", exp_q.size(), 0);
        @(posedge clock); #1;
        check("fifo_empty", res_valid, 0);
    endtask

    task automatic run_seq(input int n, input int dl[$]);
        int nrec, s0;
        s0 = kstarts;
        plan(n, dl, nrec);
        pulse_go(n);
        check("busy_after_go", busy, 1);
        wait_done(nrec, s0);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_kernel_rst_n", kernel_rst_n, 0);
        check("rst_kernel_start", kernel_start, 0);
        check("rst_res_valid", res_valid, 0);
    endtask

    initial begin
        int dl[$];
        int nrec, s0, n;

        repeat (2) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_kernel_rst_n", kernel_rst_n, 1);
        check("idle_busy0", busy, 0);
        cons_en = 1'b1;

        dl = '{10, 10, 10};
        run_seq(3, dl);
        dl = '{0};
        run_seq(1, dl);
        dl = '{1000, 1000, 1000, 1000};
        run_seq(4, dl);
        // Done on the watchdog limit cycle wins; one cycle later is a timeout.
        dl = '{49, 50};
        run_seq(2, dl);

        // Back-pressure: four results fill the FIFO and no further run may start.
        s0 = kstarts;
        cons_en = 1'b0;
        dl = '{3, 5, 2, 4, 6, 1};
        plan(6, dl, nrec);
        pulse_go(6);
        repeat (200) @(posedge clock);
        #1;
        check("stall_starts", kstarts - s0, 4);
        check("stall_busy", busy, 1);
        check("stall_valid", res_valid, 1);
        cons_en = 1'b1;
        wait_done(nrec, s0);

        go = 1'b1;
        num_runs = '0;
        @(posedge clock); #1;
        go = 1'b0;
        check("zero_seq_done", seq_done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", res_valid, 0);
        @(posedge clock); #1;
        check("zero_seq_done_end", seq_done, 0);
        check("zero_valid_end", res_valid, 0);

        s0 = kstarts;
        dl = '{20, 20};
        plan(2, dl, nrec);
        pulse_go(2);
        repeat (8) @(posedge clock);
        #1;
        go = 1'b1;
        num_runs = RUNS_W'(5);
        @(posedge clock); #1;
        go = 1'b0;
        wait_done(nrec, s0);

        dl = '{7, 11, 9};
        run_seq(3, dl);

        // Reset during WAIT of the second run with the first record still queued.
        s0 = kstarts;
        cons_en = 1'b0;
        dl = '{30, 30, 30};
        plan(3, dl, nrec);
        pulse_go(3);
        for (int k = 0; k < 300 && (kstarts - s0) < 2; k++) begin
            @(posedge clock); #1;
        end
        repeat (5) @(posedge clock);
        #1;
        check("pre_reset_valid", res_valid, 1);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals();
        exp_q.delete();
        dly_q.delete();
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_rst_n", kernel_rst_n, 1);
        check("post_reset_valid", res_valid, 0);
        cons_en = 1'b1;

        repeat (8) begin
            n = $urandom_range(5, 1);
            dl.delete();
            for (int i = 0; i < n; i++) dl.push_back($urandom_range(55, 0));
            run_seq(n, dl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
